// File: rtl/serial_pkg.sv
// Shared definitions for the serial two's-complement path: FSM encodings,
// default frame width and a width helper for counters.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;

    // Counter width able to index 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/lsb_serial_feeder_shift_reg.sv
// Parallel-load, shift-right register with bit 0 exposed; feeds the serial
// output one bit per shift, LSB first.
module lsb_shift_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             t_clk,
    input  logic             r_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             bit0
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = load_data;
        end else if (shift) begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bit0 = sr_q[0];

endmodule

// File: rtl/lsb_serial_feeder.sv
// Parallel-to-serial front end for the serial complementer: accepts a word,
// clears the downstream stage for one cycle, then emits the word LSB first.
module lsb_serial_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int GAP_CYCLES = 0
) (
    input  logic                     t_clk,
    input  logic                     r_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     ser_i,
    output logic                     ser_r,
    output logic                     busy,
    output logic                     frame_done,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int CW = clog2_min1(WIDTH);
    localparam int GW = clog2_min1(GAP_CYCLES + 1);
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          in_ready_q, in_ready_d;
    logic          ser_i_q, ser_i_d;
    logic          ser_r_q, ser_r_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          load, shift, sr_bit0;

    lsb_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
        .t_clk     (t_clk),
        .r_n       (r_n),
        .load      (load),
        .shift     (shift),
        .load_data (in_data),
        .bit0      (sr_bit0)
    );

    // Outputs are computed for the state being entered, so every output is a flop.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        in_ready_d   = 1'b0;
        ser_r_d      = 1'b1;
        ser_i_d      = 1'b0;
        busy_d       = 1'b1;
        frame_done_d = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = ST_CLEAR;
                    load    = 1'b1;
                end else begin
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_SHIFT;
                ser_r_d = 1'b0;
                ser_i_d = sr_bit0;
                shift   = 1'b1;
                cnt_d   = '0;
            end
            ST_SHIFT: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    gap_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d    = ST_IDLE;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b0;
                    end
                end else begin
                    cnt_d        = cnt_q + 1'b1;
                    ser_r_d      = 1'b0;
                    ser_i_d      = sr_bit0;
                    shift        = 1'b1;
                    frame_done_d = (cnt_d == LAST);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            gap_q        <= '0;
            in_ready_q   <= 1'b0;
            ser_i_q      <= 1'b0;
            ser_r_q      <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            in_ready_q   <= in_ready_d;
            ser_i_q      <= ser_i_d;
            ser_r_q      <= ser_r_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign ser_i      = ser_i_q;
    assign ser_r      = ser_r_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign bit_idx    = cnt_q;

endmodule

// File: tb/tb_lsb_serial_feeder.sv
// Bench for lsb_serial_feeder: scoreboard of expected serial bits plus a
// serial two's-complement model reassembling each frame.
module tb_lsb_serial_feeder;

    logic t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    logic       r_n;
    logic [7:0] in_data_a;
    logic       in_valid_a, in_ready_a, ser_i_a, ser_r_a, busy_a, frame_done_a;
    logic [2:0] bit_idx_a;
    logic [3:0] in_data_b;
    logic       in_valid_b, in_ready_b, ser_i_b, ser_r_b, busy_b, frame_done_b;
    logic [1:0] bit_idx_b;

    lsb_serial_feeder #(.WIDTH(8), .GAP_CYCLES(0)) dut_a (
        .t_clk(t_clk), .r_n(r_n), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .ser_i(ser_i_a), .ser_r(ser_r_a), .busy(busy_a),
        .frame_done(frame_done_a), .bit_idx(bit_idx_a)
    );

    lsb_serial_feeder #(.WIDTH(4), .GAP_CYCLES(2)) dut_b (
        .t_clk(t_clk), .r_n(r_n), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .ser_i(ser_i_b), .ser_r(ser_r_b), .busy(busy_b),
        .frame_done(frame_done_b), .bit_idx(bit_idx_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic       b;
        logic [2:0] idx;
    } sb_bit_t;

    sb_bit_t    bq[$];
    logic [7:0] wq[$];
    int         acc_cyc[$];
    int         cyc = 0;
    int         done_cnt = 0;
    logic       clear_pending = 1'b0;
    logic       seen1 = 1'b0;
    logic [7:0] inv_word = 8'h00;
    sb_bit_t    e;
    sb_bit_t    pe;

    always @(posedge t_clk) cyc = cyc + 1;

    // Monitor: pop expected bits while ser_r is low; push a frame when an accept is due.
    always @(negedge t_clk) begin
        if (!r_n) begin
            clear_pending = 1'b0;
            seen1         = 1'b0;
        end else begin
            if (clear_pending) begin
                check("clear_ser_r", 32'(ser_r_a), 32'd1);
                check("clear_ready", 32'(in_ready_a), 32'd0);
                clear_pending = 1'b0;
            end
            if (!ser_r_a) begin
                if (bq.size() == 0) begin
                    check("sb_underflow", 32'(bq.size()), 32'd1);
                end else begin
                    e = bq.pop_front();
                    check("ser_i", 32'(ser_i_a), 32'(e.b));
                    check("bit_idx", 32'(bit_idx_a), 32'(e.idx));
                    check("frame_done", 32'(frame_done_a), 32'(e.idx == 3'd7));
                    inv_word[e.idx] = seen1 ? ~ser_i_a : ser_i_a;
                    seen1 = seen1 | ser_i_a;
                    if (e.idx == 3'd7 && wq.size() != 0) begin
                        check("invert_word", 32'(inv_word), 32'(wq.pop_front()));
                    end
                end
            end else begin
                seen1 = 1'b0;
            end
            if (frame_done_a) done_cnt++;
            if (in_valid_a && in_ready_a) begin
                for (int i = 0; i < 8; i++) begin
                    pe.b   = in_data_a[i];
                    pe.idx = 3'(i);
                    bq.push_back(pe);
                end
                wq.push_back(8'(~in_data_a + 8'd1));
                acc_cyc.push_back(cyc);
                clear_pending = 1'b1;
            end
        end
    end

    task automatic send8(input logic [7:0] w);
        logic ok;
        ok = 1'b0;
        @(posedge t_clk); #1;
        in_data_a  = w;
        in_valid_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge t_clk);
            if (in_ready_a) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge t_clk); #1;
        in_valid_a = 1'b0;
        in_data_a  = ~w;
        check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge t_clk); #1;
            if (in_ready_a && !busy_a && bq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_bit(input logic [2:0] n);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge t_clk); #1;
            if (!ser_r_a && bit_idx_a == n) begin
                ok = 1'b1;
                break;
            end
        end
        check("bit_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         n_acc;
        int         d0;
        logic [3:0] w4;
        r_n = 1'b0;
        in_data_a = 8'h00; in_valid_a = 1'b0;
        in_data_b = 4'h0;  in_valid_b = 1'b0;

        repeat (3) @(posedge t_clk);
        #1;
        check("rst_ready", 32'(in_ready_a), 32'd0);
        check("rst_ser_r", 32'(ser_r_a), 32'd1);
        check("rst_ser_i", 32'(ser_i_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(frame_done_a), 32'd0);
        check("rst_idx", 32'(bit_idx_a), 32'd0);
        r_n = 1'b1;
        @(posedge t_clk);
        @(negedge t_clk);
        check("rel_ready", 32'(in_ready_a), 32'd1);

        // Single word: 0x06 -> complement 0xFA.
        send8(8'h06);
        wait_idle();
        check("done_count_1", 32'(done_cnt), 32'd1);

        // Back-to-back accepts spaced by WIDTH+2.
        send8(8'h80);
        send8(8'h01);
        wait_idle();
        check("b2b_period", 32'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 32'd10);

        // in_valid during SHIFT is ignored.
        n_acc = acc_cyc.size();
        send8(8'h00);
        wait_bit(3'd2);
        @(posedge t_clk); #1;
        in_data_a  = 8'h55;
        in_valid_a = 1'b1;
        @(negedge t_clk);
        check("busy_ready", 32'(in_ready_a), 32'd0);
        @(posedge t_clk); #1;
        in_valid_a = 1'b0;
        wait_idle();
        check("ignored_accepts", 32'(acc_cyc.size()), 32'(n_acc + 1));

        // Reset mid-frame abandons it without frame_done.
        d0 = done_cnt;
        send8(8'hFF);
        wait_bit(3'd3);
        r_n = 1'b0;
        #1;
        check("midrst_ser_r", 32'(ser_r_a), 32'd1);
        check("midrst_done", 32'(frame_done_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_done_cnt", 32'(done_cnt), 32'(d0));
        bq.delete();
        wq.delete();
        repeat (2) @(posedge t_clk);
        #1 r_n = 1'b1;
        send8(8'h03);
        wait_idle();
        check("post_rst_done_cnt", 32'(done_cnt), 32'(d0 + 1));

        // WIDTH=4, GAP_CYCLES=2 instance.
        w4 = 4'h5;
        @(posedge t_clk); #1;
        in_data_b  = w4;
        in_valid_b = 1'b1;
        @(negedge t_clk);
        check("g_ready", 32'(in_ready_b), 32'd1);
        @(posedge t_clk); #1;
        in_valid_b = 1'b0;
        in_data_b  = 4'hA;
        @(negedge t_clk);
        check("g_clear_r", 32'(ser_r_b), 32'd1);
        check("g_clear_busy", 32'(busy_b), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge t_clk);
            check("g_ser_r", 32'(ser_r_b), 32'd0);
            check("g_ser_i", 32'(ser_i_b), 32'(w4[i]));
            check("g_idx", 32'(bit_idx_b), 32'(i));
            check("g_done", 32'(frame_done_b), 32'(i == 3));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge t_clk);
            check("g_gap_r", 32'(ser_r_b), 32'd1);
            check("g_gap_ready", 32'(in_ready_b), 32'd0);
            check("g_gap_busy", 32'(busy_b), 32'd1);
        end
        @(negedge t_clk);
        check("g_ready_back", 32'(in_ready_b), 32'd1);
        check("g_idle_busy", 32'(busy_b), 32'd0);

        check("sb_empty", 32'(bq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
